// File: rtl/counter_sequencer_pkg.sv
// rtl/counter_sequencer_pkg.sv - shared state encoding for the counter sequencer
package counter_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/counter_sequencer_counter.sv
// rtl/counter_sequencer_counter.sv - saturating up-counter with terminal flag
module counter_sequencer_counter #(
    parameter int MAX_COUNTER_VALUE = 160,
    localparam int W = $clog2(MAX_COUNTER_VALUE + 1)
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         enable_i,
    output logic [W-1:0] counter_val_o,
    output logic         finished_o
);

    assign finished_o = (counter_val_o == W'(MAX_COUNTER_VALUE));

    // Holds at the terminal value so a tally can never wrap.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            counter_val_o <= '0;
        end else if (enable_i && !finished_o) begin
            counter_val_o <= counter_val_o + W'(1);
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - runs an external counter NUM_RUNS times per start
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int MAX_COUNTER_VALUE = 160,
    parameter int NUM_RUNS          = 4,
    localparam int VAL_W = $clog2(MAX_COUNTER_VALUE + 1),
    localparam int RUN_W = $clog2(NUM_RUNS + 1)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             abort_i,
    input  logic             counter_finished_i,
    input  logic [VAL_W-1:0] counter_val_i,
    output logic             counter_enable_o,
    output logic             counter_reset_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [RUN_W-1:0] run_count_o,
    output logic             error_o
);

    seq_state_t state;
    seq_state_t state_next;
    logic       seq_start;
    logic       finish_event;
    logic       last_run;
    logic       tally_finished;

    assign seq_start    = (state == ST_IDLE) && start_i;
    assign finish_event = (state == ST_RUN) && !abort_i && counter_finished_i;
    assign last_run     = (run_count_o == RUN_W'(NUM_RUNS - 1));

    counter_sequencer_counter #(
        .MAX_COUNTER_VALUE(NUM_RUNS)
    ) u_run_tally (
        .clock_i       (clock_i),
        .reset_i       (reset_i || seq_start),
        .enable_i      (finish_event),
        .counter_val_o (run_count_o),
        .finished_o    (tally_finished)
    );

    // Only accepted finish events can flag a short count; an aborting cycle cannot.
    always_ff @(posedge clock_i) begin
        if (reset_i || seq_start) begin
            error_o <= 1'b0;
        end else if (finish_event && (counter_val_i != VAL_W'(MAX_COUNTER_VALUE))) begin
            error_o <= 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        counter_enable_o = 1'b0;
        counter_reset_o  = 1'b0;
        done_o           = 1'b0;
        busy_o           = 1'b1;
        case (state)
            ST_IDLE: begin
                counter_reset_o = 1'b1;
                busy_o          = 1'b0;
                if (start_i) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                counter_reset_o = 1'b1;
                state_next      = abort_i ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                counter_enable_o = !pause_i;
                if (abort_i) begin
                    state_next = ST_IDLE;
                end else if (counter_finished_i) begin
                    state_next = (last_run || tally_finished) ? ST_DONE : ST_CLEAR;
                end else if (pause_i) begin
                    state_next = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (abort_i) begin
                    state_next = ST_IDLE;
                end else if (!pause_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                done_o     = !abort_i;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
